// File: rtl/gpr_wr_arb_pkg.sv
// ---------------------------------------------------------------------------
// gpr_wr_arb_pkg
// Shared widths, active-low enable encodings and bus types for the GPR
// write-port arbiter and its round-robin picker.
// ---------------------------------------------------------------------------
package gpr_wr_arb_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int WORD_DATA_W = 32;

  // Active-low enable encoding used on every *_ control signal
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
  typedef logic [WORD_DATA_W-1:0] word_data_t;

endpackage

// File: rtl/gpr_wr_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// gpr_wr_arb_rr_pick
// Purely combinational round-robin picker. Finds the first set bit of
// i_elig at or above i_ptr, wrapping from REQ_NUM-1 back to 0.
//
// Ports:
//   i_elig   [REQ_NUM-1:0]  eligible requesters (active-high)
//   i_ptr    [PTR_W-1:0]    index with highest priority this cycle
//   o_onehot [REQ_NUM-1:0]  one-hot winner (all zero when none)
//   o_idx    [PTR_W-1:0]    winner index (0 when none)
//   o_valid                 a winner exists
// ---------------------------------------------------------------------------
module gpr_wr_arb_rr_pick #(
  parameter int REQ_NUM = 4,
  parameter int PTR_W   = 2
) (
  input  logic [REQ_NUM-1:0] i_elig,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [REQ_NUM-1:0] o_onehot,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [REQ_NUM-1:0]   w_mask;
  logic [2*REQ_NUM-1:0] w_dbl;

  // Keep only requesters at or above the pointer in the lower half
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_mask[i] = (i >= int'(i_ptr));
    end
  end

  // Lower half: masked vector; upper half: full vector. The lowest set bit
  // of the concatenation is the round-robin winner; an upper-half hit is the
  // wrapped case and maps back by subtracting REQ_NUM.
  assign w_dbl = {i_elig, i_elig & w_mask};

  always_comb begin
    o_idx    = '0;
    o_onehot = '0;
    o_valid  = |i_elig;
    // Descending scan so the lowest set bit is the last one written
    for (int i = 2*REQ_NUM-1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        if (i >= REQ_NUM) o_idx = PTR_W'(i - REQ_NUM);
        else              o_idx = PTR_W'(i);
      end
    end
    o_onehot[o_idx] = o_valid;
  end

endmodule

// File: rtl/gpr_wr_arb.sv
// ---------------------------------------------------------------------------
// gpr_wr_arb
// Shares the single GPR write port among REQ_NUM write-back sources using
// round-robin arbitration. Grant and write-port outputs are registered, so
// a request seen in cycle t drives the port in cycle t+1.
//
// Handshake (requester side): a requester drives req_[i] low with stable
// req_addr/req_data and holds them until it sees gnt_[i] low. In that grant
// cycle it either releases req_[i] or presents its next request; a requester
// whose gnt_ is currently low is masked, so the next request competes one
// cycle later and a held request is never granted twice.
//
// PTR_W must equal clog2(REQ_NUM); REQ_NUM is 2..8.
//
// Ports:
//   clk          system clock
//   reset_       asynchronous active-low reset
//   flush_       synchronous active-low; blocks a grant at this edge
//   req_         per-requester write request, active-low
//   req_addr     packed addresses, requester i at [5i+4:5i]
//   req_data     packed data, requester i at [32i+31:32i]
//   gnt_         one-cycle grant pulse, active-low (registered)
//   gpr_we_      register file write enable, active-low (registered)
//   gpr_wr_addr  register file write address (registered)
//   gpr_wr_data  register file write data (registered)
//   busy         any request pending or a write in flight (combinational)
// ---------------------------------------------------------------------------
module gpr_wr_arb
  import gpr_wr_arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int PTR_W   = 2
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic                           flush_,
  input  logic [REQ_NUM-1:0]             req_,
  input  logic [REQ_NUM*REG_ADDR_W-1:0]  req_addr,
  input  logic [REQ_NUM*WORD_DATA_W-1:0] req_data,
  output logic [REQ_NUM-1:0]             gnt_,
  output logic                           gpr_we_,
  output reg_addr_t                      gpr_wr_addr,
  output word_data_t                     gpr_wr_data,
  output logic                           busy
);

  logic [REQ_NUM-1:0] r_gnt_;
  logic               r_we_;
  reg_addr_t          r_addr;
  word_data_t         r_data;
  logic [PTR_W-1:0]   r_ptr;

  logic [REQ_NUM-1:0] w_elig;
  logic [REQ_NUM-1:0] w_onehot;
  logic [PTR_W-1:0]   w_idx;
  logic               w_valid;
  reg_addr_t          w_addr;
  word_data_t         w_data;
  logic [PTR_W-1:0]   w_ptr_nxt;

  // Requesting and not holding the grant this cycle
  assign w_elig = ~req_ & r_gnt_;

  gpr_wr_arb_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .i_elig   (w_elig),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  assign w_addr = req_addr[int'(w_idx)*REG_ADDR_W  +: REG_ADDR_W];
  assign w_data = req_data[int'(w_idx)*WORD_DATA_W +: WORD_DATA_W];

  // Explicit wrap so non-power-of-two REQ_NUM works
  assign w_ptr_nxt = (w_idx == PTR_W'(REQ_NUM-1)) ? '0 : w_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_gnt_ <= '1;
      r_we_  <= DISABLE_;
      r_addr <= '0;
      r_data <= '0;
      r_ptr  <= '0;
    end else if (flush_ && w_valid) begin
      r_gnt_ <= ~w_onehot;
      r_we_  <= ENABLE_;
      r_addr <= w_addr;
      r_data <= w_data;
      r_ptr  <= w_ptr_nxt;
    end else begin
      // No winner or flushed: drop grant and write, hold addr/data/ptr
      r_gnt_ <= '1;
      r_we_  <= DISABLE_;
    end
  end

  assign gnt_        = r_gnt_;
  assign gpr_we_     = r_we_;
  assign gpr_wr_addr = r_addr;
  assign gpr_wr_data = r_data;
  assign busy        = (~&req_) | (r_we_ == ENABLE_);

endmodule

// File: tb/tb_gpr_wr_arb.sv
module tb_gpr_wr_arb;

  localparam int N  = 4;
  localparam int PW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_;
  logic          flush_;
  logic [N-1:0]  req_;
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  gnt_;
  logic          gpr_we_;
  logic [4:0]    gpr_wr_addr;
  logic [31:0]   gpr_wr_data;
  logic          busy;

  always #5 clk = ~clk;

  gpr_wr_arb #(.REQ_NUM(N), .PTR_W(PW)) dut (
    .clk         (clk),
    .reset_      (reset_),
    .flush_      (flush_),
    .req_        (req_),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .gnt_        (gnt_),
    .gpr_we_     (gpr_we_),
    .gpr_wr_addr (gpr_wr_addr),
    .gpr_wr_data (gpr_wr_data),
    .busy        (busy)
  );

  // Register file image written from the DUT's write port
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (!gpr_we_) regs[gpr_wr_addr] <= gpr_wr_data;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr;
  logic [N-1:0] m_gnt;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    m_ptr = 0; m_gnt = '1; m_we = 1'b1; m_addr = '0; m_data = '0;
    exp_q.delete();
  endtask

  // Walk requesters starting at the pointer, first eligible one wins
  task automatic model_step();
    int win = -1;
    if (flush_) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_ptr + k) % N;
        if (win < 0 && !req_[j] && m_gnt[j]) win = j;
      end
    end
    m_gnt = '1;
    if (win >= 0) begin
      m_gnt[win] = 1'b0;
      m_we   = 1'b0;
      m_addr = req_addr[win*5 +: 5];
      m_data = req_data[win*32 +: 32];
      m_ptr  = (win + 1) % N;
      exp_q.push_back({m_addr, m_data});
    end else begin
      m_we = 1'b1;
    end
  endtask

  // One model-checked cycle: inputs already applied after a posedge
  task automatic cycle();
    logic [36:0] w;
    #1;
    chk("busy", 64'(busy), 64'((~&req_) || !m_we));
    model_step();
    @(posedge clk); #1;
    chk("gnt", 64'(gnt_), 64'(m_gnt));
    chk("we", 64'(gpr_we_), 64'(m_we));
    chk("addr", 64'(gpr_wr_addr), 64'(m_addr));
    chk("data", 64'(gpr_wr_data), 64'(m_data));
    if (!gpr_we_) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=%h required=none", {gpr_wr_addr, gpr_wr_data});
      end else begin
        w = exp_q.pop_front();
        chk("write", 64'({gpr_wr_addr, gpr_wr_data}), 64'(w));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_ = 1'b0; flush_ = 1'b1; req_ = '1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_gnt", 64'(gnt_), 64'hF);
    chk("rst_we", 64'(gpr_we_), 64'h1);
    chk("rst_addr", 64'(gpr_wr_addr), 64'h0);
    chk("rst_data", 64'(gpr_wr_data), 64'h0);
    reset_ = 1'b1;
    model_reset();
  endtask

  task automatic new_req(input int i);
    req_[i] = 1'b0;
    req_addr[i*5 +: 5]   = 5'($urandom_range(0, 3));
    req_data[i*32 +: 32] = $urandom;
  endtask

  typedef struct {
    logic        flush_;
    logic [N-1:0] req_;
    logic [N-1:0] gnt_;
    logic        we_;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic f, logic [3:0] r, logic [3:0] g, logic w,
                              logic [4:0] a, logic [31:0] d);
    vec_t v;
    v.flush_ = f; v.req_ = r; v.gnt_ = g; v.we_ = w; v.addr = a; v.data = d;
    return v;
  endfunction

  initial begin
    logic [N-1:0] e;
    reset_ = 1'b0; flush_ = 1'b1; req_ = '1;
    // requester addrs: 0->8, 1->9, 2->5, 3->11
    req_addr = {5'd11, 5'd5, 5'd9, 5'd8};
    req_data = {32'hA000_0003, 32'hDEAD_BEEF, 32'hA000_0001, 32'hA000_0000};

    // single request, release, pointer wrap, self-masking, flush
    tbl.push_back(mk(1, 4'b1011, 4'b1011, 0, 5'd5,  32'hDEAD_BEEF));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 5'd5,  32'hDEAD_BEEF));
    tbl.push_back(mk(1, 4'b0110, 4'b0111, 0, 5'd11, 32'hA000_0003));
    tbl.push_back(mk(1, 4'b1110, 4'b1110, 0, 5'd8,  32'hA000_0000));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 5'd8,  32'hA000_0000));
    tbl.push_back(mk(1, 4'b1101, 4'b1101, 0, 5'd9,  32'hA000_0001));
    tbl.push_back(mk(1, 4'b1101, 4'b1111, 1, 5'd9,  32'hA000_0001));
    tbl.push_back(mk(1, 4'b1101, 4'b1101, 0, 5'd9,  32'hA000_0001));
    tbl.push_back(mk(1, 4'b1101, 4'b1111, 1, 5'd9,  32'hA000_0001));
    tbl.push_back(mk(1, 4'b1101, 4'b1101, 0, 5'd9,  32'hA000_0001));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 5'd9,  32'hA000_0001));
    tbl.push_back(mk(0, 4'b1110, 4'b1111, 1, 5'd9,  32'hA000_0001));
    tbl.push_back(mk(0, 4'b1110, 4'b1111, 1, 5'd9,  32'hA000_0001));
    tbl.push_back(mk(1, 4'b1110, 4'b1110, 0, 5'd8,  32'hA000_0000));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 1, 5'd8,  32'hA000_0000));

    do_reset();
    for (int v = 0; v < tbl.size(); v++) begin
      flush_ = tbl[v].flush_;
      req_   = tbl[v].req_;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_gnt", v),  64'(gnt_),        64'(tbl[v].gnt_));
      chk($sformatf("tbl%0d_we", v),   64'(gpr_we_),     64'(tbl[v].we_));
      chk($sformatf("tbl%0d_addr", v), 64'(gpr_wr_addr), 64'(tbl[v].addr));
      chk($sformatf("tbl%0d_data", v), 64'(gpr_wr_data), 64'(tbl[v].data));
    end
    chk("gpr_r5", 64'(regs[5]), 64'hDEAD_BEEF);
    chk("gpr_r11", 64'(regs[11]), 64'hA000_0003);

    // full contention: every requester re-requests right after its grant
    do_reset();
    req_addr = {5'd23, 5'd22, 5'd21, 5'd20};
    req_ = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      e = '1; e[k % N] = 1'b0;
      chk($sformatf("cont%0d_gnt", k), 64'(gnt_), 64'(e));
      chk($sformatf("cont%0d_we", k), 64'(gpr_we_), 64'h0);
      chk($sformatf("cont%0d_addr", k), 64'(gpr_wr_addr), 64'(20 + (k % N)));
    end
    req_ = '1;

    // reset asserted while requester 2 holds the grant
    do_reset();
    req_ = 4'b1011;
    @(posedge clk); #1;
    chk("mid_gnt_before", 64'(gnt_), 64'hB);
    reset_ = 1'b0;
    #1;
    chk("mid_gnt_async", 64'(gnt_), 64'hF);
    chk("mid_we_async", 64'(gpr_we_), 64'h1);
    chk("mid_addr_async", 64'(gpr_wr_addr), 64'h0);
    chk("mid_data_async", 64'(gpr_wr_data), 64'h0);
    #1;
    reset_ = 1'b1;
    req_ = 4'b0110;
    @(posedge clk); #1;
    chk("mid_gnt_after", 64'(gnt_), 64'hE);
    chk("mid_addr_after", 64'(gpr_wr_addr), 64'd20);
    req_ = '1;

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      flush_ = ($urandom_range(0, 7) != 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (!req_[i]) begin
          if (!gnt_[i]) begin
            if ($urandom_range(0, 1) == 1) new_req(i);
            else req_[i] = 1'b1;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
    end
    req_ = '1; flush_ = 1'b1;
    cycle();
    cycle();
    chk("drain_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_wr_arb.md
Name: gpr_wr_arb

Overview:
- Shares the single general-purpose-register write port (we_, wr_addr, wr_data) among REQ_NUM write-back requesters, e.g. the EX result, load return, multi-cycle mul/div and CSR move.
- Uses round-robin arbitration with a registered grant, and drives the register file write port directly from registered outputs.
- Sits between the pipeline write-back sources and gpr.

Parameters:
- REQ_NUM, 4, number of requesters (2..8).
- PTR_W, 2, pointer width; equals clog2(REQ_NUM).

Ports:
- clk  in  1  system clock.
- reset_  in  1  asynchronous, active-low reset.
- flush_  in  1  synchronous, active-low; suppresses the grant at this edge.
- req_  in  REQ_NUM  per-requester write request, active-low.
- req_addr  in  REQ_NUM*5  register addresses; requester i occupies bits [5i+4:5i].
- req_data  in  REQ_NUM*32  write data; requester i occupies bits [32i+31:32i].
- gnt_  out  REQ_NUM  one-cycle grant pulse, active-low.
- gpr_we_  out  1  register file write enable, active-low.
- gpr_wr_addr  out  5  register file write address.
- gpr_wr_data  out  32  register file write data.
- busy  out  1  high when any req_ is low or gpr_we_ is low.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_.
- Reset values:
  - gnt_ = all 1.
  - gpr_we_ = 1.
  - gpr_wr_addr = 0.
  - gpr_wr_data = 0.
  - Internal pointer ptr = 0.
- Reset mid-operation: an in-flight grant or write is dropped immediately; nothing is replayed.
- Eligibility: requester i is eligible in cycle t when req_[i] is low in t and gnt_[i] is high in t. A requester that is currently granted is masked, which prevents a double grant while its req_ is still held.
- Selection: combinational round-robin among eligible requesters, searching from index ptr upward and wrapping at REQ_NUM-1 to 0.
- Posedge ending cycle t, when a winner w exists and flush_ is high:
  - gnt_[w] goes low for exactly one cycle.
  - gpr_we_ goes low.
  - gpr_wr_addr and gpr_wr_data load w's address and data.
  - ptr becomes (w+1) mod REQ_NUM.
  - gpr performs the write at the following edge.
  - Latency from request to grant and write-port drive is 1 cycle.
- Posedge with no winner, or with flush_ low: gnt_ = all 1, gpr_we_ = 1, addr/data hold their previous values, ptr unchanged.
- Handshake (requester side):
  - Assert req_ with stable addr/data and hold until gnt_[i] is seen low.
  - In the grant cycle, either deassert req_ or present the next request; that next request becomes eligible one cycle later.
  - Consequence: per-requester throughput is at most 1 write per 2 cycles; the port reaches 1 write per cycle with 2 or more active requesters.
- Same-address requests in the same cycle: no merging; both are written in grant order, so the last grant wins.
- Address 0 is written like any other register; no special case.
- Flush: requests are not dropped, only deferred. A requester still holding req_ low is granted after flush_ returns high.
- busy is purely combinational; all other outputs are registered.

Decomposition:
- Shared header (cpu.h / stddef.h):
  - REG_ADDR_W = 5, WORD_DATA_W = 32.
  - ENABLE_ = 1'b0, DISABLE_ = 1'b1.
  - RegAddrBus and WordDataBus ranges.
- Sub-module rr_pick: purely combinational.
  - Inputs: eligible vector and ptr.
  - Outputs: one-hot winner, winner index, valid.
  - Implemented as a double-width masked priority encoder.
- gpr_wr_arb instantiates rr_pick and holds the pointer, grant, write-port registers and data muxing.

Test Plan:
- Single request (REQ_NUM=4):
  - Stimulus: req_[2] low with addr 5, data 32'hDEADBEEF in cycle 0.
  - Response: cycle 1 has gnt_ = 4'b1011, gpr_we_ = 0, addr 5, data DEADBEEF. Cycle 2 has gnt_ = 4'b1111 and gpr_we_ = 1 (req_ released); gpr r5 reads DEADBEEF.
- Full contention:
  - Stimulus: all req_ low continuously, each requester presenting a new request after its grant.
  - Response: grants go to 0,1,2,3,0,1... on consecutive cycles, and gpr_we_ stays low every cycle.
- Self-masking:
  - Stimulus: only req_[1] held low for 6 cycles.
  - Response: gnt_[1] is low in cycles 1, 3 and 5 only.
- Pointer wrap:
  - Stimulus: ptr = 3 (after a grant to 2), then req_[3] and req_[0] both low.
  - Response: 3 is granted first, then 0; ptr ends at 1.
- Flush:
  - Stimulus: req_[0] low, flush_ low for cycles 0-1.
  - Response: no grant and gpr_we_ = 1 through cycle 2; grant to 0 in cycle 3; ptr unchanged until then.
- Reset mid-operation:
  - Stimulus: reset_ pulsed low while gnt_[2] is low; after release, req_[3] and req_[0] low.
  - Response: outputs go to reset values asynchronously; 0 wins first because ptr = 0.
